// File: rtl/lat_pkg.sv
// Shared constants and width helpers for the fixed-latency delay line and its output buffer.
// Pure declarations: no logic, no latency, no flow control.
package lat_pkg;

    localparam int LAT_DATA_WIDTH = 8;
    localparam int LAT_LATENCY    = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Counter that must be able to hold the value 'depth' itself.
    function automatic int cnt_w(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/lat_credit_ctr.sv
// Up/down saturating credit counter for stages without backpressure; flags issue with no credit.
// Latency: o_ok is combinational from the count register; updates land one cycle after i_dec/i_inc.
// Backpressure: none; an i_dec while empty is ignored and latches the sticky o_err flag.
module lat_credit_ctr
    import lat_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cnt_w(MAX)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_dec,
    input  logic i_inc,
    output logic o_ok,
    output logic o_err
);

    localparam logic [W-1:0] MAXV = W'(MAX);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] r_cnt;
    logic         r_err;
    logic         w_take;
    logic         w_full;

    assign w_take = i_dec & (r_cnt != '0);
    assign w_full = (r_cnt == MAXV);
    assign o_ok   = (r_cnt != '0);
    assign o_err  = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= MAXV;
            r_err <= 1'b0;
        end else begin
            if (w_take && !i_inc) begin
                r_cnt <= r_cnt - ONE;
            end else if (i_inc && !w_take && !w_full) begin
                r_cnt <= r_cnt + ONE;
            end
            if (i_dec && (r_cnt == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/latency_credit_buf.sv
// Credit-managed FWFT output buffer behind a no-backpressure delay line. Optional: LATENCY_CREDIT_BUF_STATS_EN.
// Latency: in_valid sampled at one edge is visible on m_valid/m_data right after that edge.
// Backpressure: m_ready stalls the FIFO; upstream is throttled only through issue_ok credits.
module latency_credit_buf
    import lat_pkg::*;
#(
    parameter int DATA_WIDTH = LAT_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue,
    output logic                      issue_ok,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      m_valid,
    output logic [DATA_WIDTH-1:0]     m_data,
    input  logic                      m_ready,
    output logic                      err_credit,
    output logic                      err_ovf
`ifdef LATENCY_CREDIT_BUF_STATS_EN
    ,
    output logic [cnt_w(DEPTH)-1:0]   occ_max,
    output logic [15:0]               drop_cnt
`endif
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_rd;
    logic [PW-1:0]         r_wr;
    logic [CW-1:0]         r_count;
    logic                  r_err_ovf;

    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_ovf;

    assign m_valid = (r_count != '0);
    // Gate the head read so m_data is defined-zero while empty (storage is never reset).
    assign m_data  = m_valid ? r_mem[r_rd] : '0;
    assign w_pop   = m_valid & m_ready;
    assign w_full  = (r_count == DEPTH_C);
    assign w_push  = in_valid & (!w_full | w_pop);
    assign w_ovf   = in_valid & w_full & !w_pop;
    assign err_ovf = r_err_ovf;

    lat_credit_ctr #(
        .MAX (DEPTH)
    ) u_credit (
        .clk   (clk),
        .rst_n (rst_n),
        .i_dec (issue),
        .i_inc (w_pop),
        .o_ok  (issue_ok),
        .o_err (err_credit)
    );

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd      <= '0;
            r_wr      <= '0;
            r_count   <= '0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= (r_wr == LAST) ? '0 : r_wr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd <= (r_rd == LAST) ? '0 : r_rd + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
            if (w_ovf) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

`ifdef LATENCY_CREDIT_BUF_STATS_EN
    logic [CW-1:0] r_occ_max;
    logic [15:0]   r_drop_cnt;

    assign occ_max  = r_occ_max;
    assign drop_cnt = r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ_max  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (r_count > r_occ_max) begin
                r_occ_max <= r_count;
            end
            if (w_ovf && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_latency_credit_buf.sv
// Directed bench for latency_credit_buf behind a LAT_LATENCY-stage delay-line model.
// A scoreboard queue holds every word expected to reach the consumer, in order.
module tb_latency_credit_buf;
    import lat_pkg::*;

    localparam int DW    = LAT_DATA_WIDTH;
    localparam int DEPTH = 4;
    localparam int LAT   = LAT_LATENCY;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          issue = 1'b0;
    logic [DW-1:0] issue_dat = '0;
    logic          issue_ok;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic          err_credit;
    logic          err_ovf;
    logic          inj_vld = 1'b0;
    logic [DW-1:0] inj_dat = '0;
`ifdef LATENCY_CREDIT_BUF_STATS_EN
    logic [cnt_w(DEPTH)-1:0] occ_max;
    logic [15:0]             drop_cnt;
`endif

    logic [LAT-1:0] dl_vld;
    logic [DW-1:0]  dl_dat [LAT];

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    // Delay-line model: no backpressure, flushed by the shared reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld <= '0;
        end else begin
            dl_vld    <= {dl_vld[LAT-2:0], issue};
            dl_dat[0] <= issue_dat;
            for (int i = 1; i < LAT; i++) dl_dat[i] <= dl_dat[i-1];
        end
    end

    assign in_valid = dl_vld[LAT-1] | inj_vld;
    assign in_data  = inj_vld ? inj_dat : dl_dat[LAT-1];

    latency_credit_buf #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (issue),
        .issue_ok   (issue_ok),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .err_credit (err_credit),
        .err_ovf    (err_ovf)
`ifdef LATENCY_CREDIT_BUF_STATS_EN
        ,
        .occ_max    (occ_max),
        .drop_cnt   (drop_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [DW-1:0] d);
        issue     = 1'b1;
        issue_dat = d;
        tick();
        issue     = 1'b0;
    endtask

    // Consumer side: every handshake must deliver the next expected word.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            check("pop_has_expect", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("pop_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int n;
        int guard;

        #1 rst_n = 1'b0;
        #3;
        check("rst_issue_ok", 32'(issue_ok), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_err_credit", 32'(err_credit), 32'd0);
        check("rst_err_ovf", 32'(err_ovf), 32'd0);
        #8 rst_n = 1'b1;
        tick();
        check("idle_m_valid", 32'(m_valid), 32'd0);

        // Single word: one cycle from in_valid sample to m_valid.
        m_ready = 1'b0;
        exp_q.push_back(8'h11);
        do_issue(8'h11);
        tick();
        check("lat_e1_m_valid", 32'(m_valid), 32'd0);
        tick();
        check("lat_e2_in_valid", 32'(in_valid), 32'd1);
        check("lat_e2_m_valid", 32'(m_valid), 32'd0);
        tick();
        check("lat_e3_m_valid", 32'(m_valid), 32'd1);
        check("lat_e3_m_data", 32'(m_data), 32'h11);
        m_ready = 1'b1;
        tick();
        check("lat_popped", 32'(m_valid), 32'd0);

        // Streaming with a well-behaved issuer and an always-ready consumer.
        n = 1;
        guard = 0;
        while (n <= 8 && guard < 40) begin
            if (issue_ok) begin
                exp_q.push_back(DW'(n));
                issue     = 1'b1;
                issue_dat = DW'(n);
                n++;
            end else begin
                issue = 1'b0;
            end
            tick();
            guard++;
        end
        issue = 1'b0;
        check("stream_issued", 32'(n), 32'd9);
        repeat (8) tick();
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        check("stream_m_valid", 32'(m_valid), 32'd0);
        check("stream_err_credit", 32'(err_credit), 32'd0);
        check("stream_err_ovf", 32'(err_ovf), 32'd0);

        // Stalled consumer: credits run out after DEPTH issues.
        m_ready = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            check("stall_issue_ok", 32'(issue_ok), 32'd1);
            exp_q.push_back(DW'(k));
            do_issue(DW'(k));
        end
        check("stall_issue_ok_low", 32'(issue_ok), 32'd0);
        repeat (4) tick();
        check("stall_m_valid", 32'(m_valid), 32'd1);
        check("stall_head", 32'(m_data), 32'd1);
        check("stall_err_ovf", 32'(err_ovf), 32'd0);
        repeat (3) tick();
        check("stall_hold_valid", 32'(m_valid), 32'd1);
        check("stall_hold_head", 32'(m_data), 32'd1);

        // Full FIFO: push of 5 lands in the slot freed by popping 1.
        inj_vld = 1'b1;
        inj_dat = 8'h05;
        exp_q.push_back(8'h05);
        m_ready = 1'b1;
        tick();
        inj_vld = 1'b0;
        m_ready = 1'b0;
        check("fullpp_head", 32'(m_data), 32'd2);
        check("fullpp_m_valid", 32'(m_valid), 32'd1);
        check("fullpp_err_ovf", 32'(err_ovf), 32'd0);

        // Overflow: word arriving at a full, stalled FIFO is dropped.
        inj_vld = 1'b1;
        inj_dat = 8'h99;
        tick();
        inj_vld = 1'b0;
        check("ovf_err", 32'(err_ovf), 32'd1);
        check("ovf_head", 32'(m_data), 32'd2);

        // One credit came back with the pop; spend it, then issue illegally.
        check("cred_ok_before", 32'(issue_ok), 32'd1);
        do_issue(8'hA0);
        check("cred_ok_spent", 32'(issue_ok), 32'd0);
        do_issue(8'hA1);
        check("cred_err", 32'(err_credit), 32'd1);
        check("cred_stay_zero", 32'(issue_ok), 32'd0);
        repeat (5) tick();
        check("drop_head", 32'(m_data), 32'd2);

        // Drain 2,3,4,5; credits return to DEPTH, error flags stay set.
        m_ready = 1'b1;
        repeat (6) tick();
        check("drain_empty_q", 32'(exp_q.size()), 32'd0);
        check("drain_m_valid", 32'(m_valid), 32'd0);
        check("drain_issue_ok", 32'(issue_ok), 32'd1);
        check("sticky_err_credit", 32'(err_credit), 32'd1);
        check("sticky_err_ovf", 32'(err_ovf), 32'd1);
`ifdef LATENCY_CREDIT_BUF_STATS_EN
        check("stats_occ_max", 32'(occ_max), 32'd4);
        check("stats_drop_cnt", 32'(drop_cnt), 32'd3);
`endif

        // Reset with words buffered: everything is discarded asynchronously.
        m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        check("rst2_err_credit", 32'(err_credit), 32'd0);
        check("rst2_err_ovf", 32'(err_ovf), 32'd0);
        for (int k = 0; k < 3; k++) do_issue(DW'(8'h31 + k));
        repeat (4) tick();
        check("mid_m_valid", 32'(m_valid), 32'd1);
        check("mid_head", 32'(m_data), 32'h31);
        #2 rst_n = 1'b0;
        #1;
        check("arst_m_valid", 32'(m_valid), 32'd0);
        check("arst_m_data", 32'(m_data), 32'd0);
        check("arst_issue_ok", 32'(issue_ok), 32'd1);
        #3 rst_n = 1'b1;
        tick();

        // Credits are back at DEPTH: exactly DEPTH issues allowed.
        for (int k = 0; k < DEPTH; k++) begin
            check("post_rst_issue_ok", 32'(issue_ok), 32'd1);
            exp_q.push_back(DW'(8'h41 + k));
            do_issue(DW'(8'h41 + k));
        end
        check("post_rst_ok_low", 32'(issue_ok), 32'd0);
        repeat (4) tick();
        check("post_rst_head", 32'(m_data), 32'h41);
        m_ready = 1'b1;
        repeat (6) tick();
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);
        check("post_rst_err_ovf", 32'(err_ovf), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
